// File: rtl/hamming_candidate_scan.sv
// Sweeps every candidate word of width n, finds its minimum Hamming distance
// to a stored code set through a registered popcount stage, and streams out
// candidates meeting min_hd (flagged when they also meet min_iso).
module hamming_candidate_scan #(
  parameter int WIDTH    = 8,
  parameter int MAX_CODE = 16,
  parameter int DW       = $clog2(WIDTH + 1),
  parameter int CW       = $clog2(MAX_CODE + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               code_clear,
  input  logic               code_wr_en,
  input  logic [WIDTH-1:0]   code_wr_data,
  output logic [CW-1:0]      code_count,
  output logic               code_full,
  input  logic               start,
  input  logic [DW-1:0]      n,
  input  logic [DW-1:0]      min_hd,
  input  logic [DW-1:0]      min_iso,
  output logic               busy,
  output logic               done,
  output logic               cand_valid,
  input  logic               cand_ready,
  output logic [WIDTH-1:0]   cand_data,
  output logic               cand_iso,
  output logic [DW-1:0]      cand_dist,
  output logic [WIDTH:0]     pass_count,
  output logic [WIDTH:0]     iso_count
);

  localparam int AW = (MAX_CODE > 1) ? $clog2(MAX_CODE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_DRAIN,
    S_DECIDE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      n_q, n_d;
  logic [DW-1:0]      min_hd_q, min_hd_d;
  logic [DW-1:0]      min_iso_q, min_iso_d;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic [DW-1:0]      pc_q, pc_d;
  logic               pc_valid_q, pc_valid_d;
  logic [DW-1:0]      min_acc_q, min_acc_d;
  logic [CW-1:0]      code_count_q, code_count_d;
  logic               cand_valid_q, cand_valid_d;
  logic [WIDTH-1:0]   cand_data_q, cand_data_d;
  logic               cand_iso_q, cand_iso_d;
  logic [DW-1:0]      cand_dist_q, cand_dist_d;
  logic [WIDTH:0]     pass_count_q, pass_count_d;
  logic [WIDTH:0]     iso_count_q, iso_count_d;

  logic [WIDTH-1:0]   code_mem_q [MAX_CODE];
  logic               code_we;
  logic [AW-1:0]      code_waddr;

  logic               full;
  logic [DW-1:0]      n_clamp;
  logic [WIDTH:0]     cand_limit;
  logic               last_cand;
  logic               do_advance;

  // Number of set bits over the full word width.
  function automatic logic [DW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [DW-1:0] c;
    // NOTE: blocking assignments are correct here and in always_comb; they
    // model combinational evaluation order, never state.
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + DW'(v[i]);
    return c;
  endfunction

  assign full       = (code_count_q == CW'(MAX_CODE));
  assign n_clamp    = (n > DW'(WIDTH)) ? DW'(WIDTH) : n;
  assign cand_limit = ((WIDTH+1)'(1) << n_q) - (WIDTH+1)'(1);
  assign last_cand  = ({1'b0, cand_q} == cand_limit);
  assign code_waddr = code_count_q[AW-1:0];

  // Next-state, code-set maintenance, distance accumulation and output staging.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    n_d          = n_q;
    min_hd_d     = min_hd_q;
    min_iso_d    = min_iso_q;
    cand_d       = cand_q;
    idx_d        = idx_q;
    pc_d         = pc_q;
    pc_valid_d   = 1'b0;
    min_acc_d    = min_acc_q;
    code_count_d = code_count_q;
    cand_valid_d = cand_valid_q;
    cand_data_d  = cand_data_q;
    cand_iso_d   = cand_iso_q;
    cand_dist_d  = cand_dist_q;
    pass_count_d = pass_count_q;
    iso_count_d  = iso_count_q;
    code_we      = 1'b0;
    do_advance   = 1'b0;

    // Fold the popcount issued last cycle into the running minimum.
    if (pc_valid_q && (pc_q < min_acc_q)) min_acc_d = pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (code_clear) begin
          code_count_d = '0;
        end else if (code_wr_en && !full) begin
          code_we      = 1'b1;
          code_count_d = code_count_q + CW'(1);
        end
        if (start) begin
          n_d          = n_clamp;
          min_hd_d     = min_hd;
          min_iso_d    = min_iso;
          pass_count_d = '0;
          iso_count_d  = '0;
          cand_d       = '0;
          idx_d        = '0;
          min_acc_d    = n_clamp;
          state_d      = (code_count_d == '0) ? S_DECIDE : S_COMPARE;
        end
      end
      S_COMPARE: begin
        pc_d       = popcount(cand_q ^ code_mem_q[idx_q[AW-1:0]]);
        pc_valid_d = 1'b1;
        if (idx_q == code_count_q - CW'(1)) state_d = S_DRAIN;
        else                                 idx_d   = idx_q + CW'(1);
      end
      S_DRAIN: begin
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (min_acc_q >= min_hd_q) begin
          cand_valid_d = 1'b1;
          cand_data_d  = cand_q;
          cand_dist_d  = min_acc_q;
          cand_iso_d   = (min_acc_q >= min_iso_q);
          pass_count_d = pass_count_q + (WIDTH+1)'(1);
          if (min_acc_q >= min_iso_q) iso_count_d = iso_count_q + (WIDTH+1)'(1);
          state_d      = S_EMIT;
        end else begin
          do_advance = 1'b1;
        end
      end
      S_EMIT: begin
        if (cand_ready) begin
          cand_valid_d = 1'b0;
          do_advance   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Move to the next candidate, or finish after the all-ones candidate.
    if (do_advance) begin
      if (last_cand) begin
        state_d = S_DONE;
      end else begin
        cand_d    = cand_q + WIDTH'(1);
        min_acc_d = n_q;
        idx_d     = '0;
        state_d   = (code_count_q == '0) ? S_DECIDE : S_COMPARE;
      end
    end
  end

  // State and control registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      min_hd_q     <= '0;
      min_iso_q    <= '0;
      cand_q       <= '0;
      idx_q        <= '0;
      pc_q         <= '0;
      pc_valid_q   <= 1'b0;
      min_acc_q    <= '0;
      code_count_q <= '0;
      cand_valid_q <= 1'b0;
      cand_data_q  <= '0;
      cand_iso_q   <= 1'b0;
      cand_dist_q  <= '0;
      pass_count_q <= '0;
      iso_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      min_hd_q     <= min_hd_d;
      min_iso_q    <= min_iso_d;
      cand_q       <= cand_d;
      idx_q        <= idx_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      min_acc_q    <= min_acc_d;
      code_count_q <= code_count_d;
      cand_valid_q <= cand_valid_d;
      cand_data_q  <= cand_data_d;
      cand_iso_q   <= cand_iso_d;
      cand_dist_q  <= cand_dist_d;
      pass_count_q <= pass_count_d;
      iso_count_q  <= iso_count_d;
    end
  end

  // Code-set storage, appended at the current count.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; code_count alone
    // decides which entries are meaningful, so stale contents are harmless.
    if (code_we) code_mem_q[code_waddr] <= code_wr_data;
  end

  assign code_count = code_count_q;
  assign code_full  = full;
  assign busy       = (state_q == S_COMPARE) || (state_q == S_DRAIN) ||
                      (state_q == S_DECIDE)  || (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);
  assign cand_valid = cand_valid_q;
  assign cand_data  = cand_data_q;
  assign cand_iso   = cand_iso_q;
  assign cand_dist  = cand_dist_q;
  assign pass_count = pass_count_q;
  assign iso_count  = iso_count_q;

endmodule

// File: tb/tb_hamming_candidate_scan.sv
// Directed self-checking bench for hamming_candidate_scan.
module tb_hamming_candidate_scan;

  localparam int WIDTH    = 8;
  localparam int MAX_CODE = 16;
  localparam int DW       = 4;
  localparam int CW       = 5;

  logic               clock;
  logic               reset_n;
  logic               code_clear;
  logic               code_wr_en;
  logic [WIDTH-1:0]   code_wr_data;
  logic [CW-1:0]      code_count;
  logic               code_full;
  logic               start;
  logic [DW-1:0]      n;
  logic [DW-1:0]      min_hd;
  logic [DW-1:0]      min_iso;
  logic               busy;
  logic               done;
  logic               cand_valid;
  logic               cand_ready;
  logic [WIDTH-1:0]   cand_data;
  logic               cand_iso;
  logic [DW-1:0]      cand_dist;
  logic [WIDTH:0]     pass_count;
  logic [WIDTH:0]     iso_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] cap_data [$];
  logic             cap_iso  [$];
  logic [DW-1:0]    cap_dist [$];
  int               busy_at;
  int               done_at;
  logic             busy_at_done;

  hamming_candidate_scan #(.WIDTH(WIDTH), .MAX_CODE(MAX_CODE)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .code_clear   (code_clear),
    .code_wr_en   (code_wr_en),
    .code_wr_data (code_wr_data),
    .code_count   (code_count),
    .code_full    (code_full),
    .start        (start),
    .n            (n),
    .min_hd       (min_hd),
    .min_iso      (min_iso),
    .busy         (busy),
    .done         (done),
    .cand_valid   (cand_valid),
    .cand_ready   (cand_ready),
    .cand_data    (cand_data),
    .cand_iso     (cand_iso),
    .cand_dist    (cand_dist),
    .pass_count   (pass_count),
    .iso_count    (iso_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_code(input logic [WIDTH-1:0] d);
    code_wr_en   = 1'b1;
    code_wr_data = d;
    tick();
    code_wr_en   = 1'b0;
  endtask

  task automatic clear_codes();
    code_clear = 1'b1;
    tick();
    code_clear = 1'b0;
  endtask

  task automatic start_scan(input logic [DW-1:0] nn, input logic [DW-1:0] hd,
                            input logic [DW-1:0] iso);
    n       = nn;
    min_hd  = hd;
    min_iso = iso;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Record every handshake until done; cycle indices are relative to entry.
  task automatic collect(input int budget);
    cap_data.delete();
    cap_iso.delete();
    cap_dist.delete();
    busy_at      = -1;
    done_at      = -1;
    busy_at_done = 1'bx;
    for (int c = 0; c < budget; c++) begin
      if (busy === 1'b1 && busy_at < 0) busy_at = c;
      if (cand_valid === 1'b1 && cand_ready === 1'b1) begin
        cap_data.push_back(cand_data);
        cap_iso.push_back(cand_iso);
        cap_dist.push_back(cand_dist);
      end
      if (done === 1'b1) begin
        done_at      = c;
        busy_at_done = busy;
        break;
      end
      tick();
    end
    if (done_at < 0) begin
      n_checks++; n_fail++;
      $display("FAIL collect_timeout: done not seen within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL rst_done: got %0b want 0", done); end
    n_checks++; if (cand_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", cand_valid); end
    n_checks++; if (cand_data !== '0)    begin n_fail++; $display("FAIL rst_data: got %0h want 0", cand_data); end
    n_checks++; if (cand_iso !== 1'b0)   begin n_fail++; $display("FAIL rst_iso: got %0b want 0", cand_iso); end
    n_checks++; if (cand_dist !== '0)    begin n_fail++; $display("FAIL rst_dist: got %0d want 0", cand_dist); end
    n_checks++; if (pass_count !== '0)   begin n_fail++; $display("FAIL rst_pass: got %0d want 0", pass_count); end
    n_checks++; if (iso_count !== '0)    begin n_fail++; $display("FAIL rst_isoc: got %0d want 0", iso_count); end
    n_checks++; if (code_count !== '0)   begin n_fail++; $display("FAIL rst_count: got %0d want 0", code_count); end
    n_checks++; if (code_full !== 1'b0)  begin n_fail++; $display("FAIL rst_full: got %0b want 0", code_full); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [WIDTH-1:0] exp_d [5] = '{8'd7, 8'd11, 8'd13, 8'd14, 8'd15};
    logic             exp_i [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [DW-1:0]    exp_t [5] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    clear_codes();
    write_code(8'h00);
    start_scan(4'd4, 4'd3, 4'd4);
    collect(200);
    n_checks++;
    if (cap_data.size() != 5) begin n_fail++; $display("FAIL single_n_emit: got %0d want 5", cap_data.size()); end
    for (int i = 0; i < 5 && i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[i] !== exp_d[i] || cap_iso[i] !== exp_i[i] || cap_dist[i] !== exp_t[i]) begin
        n_fail++;
        $display("FAIL single_emit[%0d]: got data=%0d iso=%0b dist=%0d want data=%0d iso=%0b dist=%0d",
                 i, cap_data[i], cap_iso[i], cap_dist[i], exp_d[i], exp_i[i], exp_t[i]);
      end
    end
    n_checks++; if (pass_count !== 9'd5) begin n_fail++; $display("FAIL single_pass: got %0d want 5", pass_count); end
    n_checks++; if (iso_count !== 9'd1)  begin n_fail++; $display("FAIL single_isoc: got %0d want 1", iso_count); end
    // 11 rejects x 3 cycles + 5 passes x 4 cycles
    n_checks++; if (done_at - busy_at != 53) begin n_fail++; $display("FAIL single_cycles: got %0d want 53", done_at - busy_at); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %0b want 0", busy_at_done); end
  endtask

  task automatic test_two_word();
    logic [WIDTH-1:0] exp_d [6] = '{8'd3, 8'd5, 8'd6, 8'd9, 8'd10, 8'd12};
    clear_codes();
    write_code(8'h00);
    write_code(8'h0F);
    start_scan(4'd4, 4'd2, 4'd3);
    collect(300);
    n_checks++;
    if (cap_data.size() != 6) begin n_fail++; $display("FAIL two_n_emit: got %0d want 6", cap_data.size()); end
    for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[i] !== exp_d[i] || cap_iso[i] !== 1'b0 || cap_dist[i] !== 4'd2) begin
        n_fail++;
        $display("FAIL two_emit[%0d]: got data=%0d iso=%0b dist=%0d want data=%0d iso=0 dist=2",
                 i, cap_data[i], cap_iso[i], cap_dist[i], exp_d[i]);
      end
    end
    n_checks++; if (pass_count !== 9'd6) begin n_fail++; $display("FAIL two_pass: got %0d want 6", pass_count); end
    n_checks++; if (iso_count !== 9'd0)  begin n_fail++; $display("FAIL two_isoc: got %0d want 0", iso_count); end
    // 10 rejects x 4 cycles + 6 passes x 5 cycles
    n_checks++; if (done_at - busy_at != 70) begin n_fail++; $display("FAIL two_cycles: got %0d want 70", done_at - busy_at); end
  endtask

  task automatic test_empty_set();
    clear_codes();
    start_scan(4'd3, 4'd3, 4'd3);
    collect(100);
    n_checks++;
    if (cap_data.size() != 8) begin n_fail++; $display("FAIL empty_n_emit: got %0d want 8", cap_data.size()); end
    for (int i = 0; i < 8 && i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[i] !== WIDTH'(i) || cap_iso[i] !== 1'b1 || cap_dist[i] !== 4'd3) begin
        n_fail++;
        $display("FAIL empty_emit[%0d]: got data=%0d iso=%0b dist=%0d want data=%0d iso=1 dist=3",
                 i, cap_data[i], cap_iso[i], cap_dist[i], i);
      end
    end
    n_checks++; if (iso_count !== 9'd8) begin n_fail++; $display("FAIL empty_isoc: got %0d want 8", iso_count); end
    n_checks++; if (done_at - busy_at != 16) begin n_fail++; $display("FAIL empty_cycles: got %0d want 16", done_at - busy_at); end

    start_scan(4'd3, 4'd4, 4'd3);
    collect(100);
    n_checks++; if (cap_data.size() != 0) begin n_fail++; $display("FAIL empty_hd4_n_emit: got %0d want 0", cap_data.size()); end
    n_checks++; if (pass_count !== 9'd0) begin n_fail++; $display("FAIL empty_hd4_pass: got %0d want 0", pass_count); end
    n_checks++; if (done_at - busy_at != 8) begin n_fail++; $display("FAIL empty_hd4_cycles: got %0d want 8", done_at - busy_at); end
    n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL empty_hd4_busy_at_done: got %0b want 0", busy_at_done); end

    // n = 0 scans only candidate 0, with distance 0
    start_scan(4'd0, 4'd0, 4'd0);
    collect(50);
    n_checks++;
    if (cap_data.size() != 1 || cap_data[0] !== 8'd0 || cap_dist[0] !== 4'd0 || cap_iso[0] !== 1'b1) begin
      n_fail++; $display("FAIL n0_emit: got %0d emits (first data/dist/iso checked) want one emit of 0 dist 0 iso 1", cap_data.size());
    end
    n_checks++; if (done_at - busy_at != 2) begin n_fail++; $display("FAIL n0_cycles: got %0d want 2", done_at - busy_at); end

    // n above WIDTH clamps to WIDTH: 256 candidates, all at distance 8
    start_scan(4'd12, 4'd9, 4'd9);
    collect(400);
    n_checks++; if (cap_data.size() != 0) begin n_fail++; $display("FAIL clamp_n_emit: got %0d want 0", cap_data.size()); end
    n_checks++; if (done_at - busy_at != 256) begin n_fail++; $display("FAIL clamp_cycles: got %0d want 256", done_at - busy_at); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_d [3] = '{8'd1, 8'd2, 8'd3};
    logic [DW-1:0]    exp_t [3] = '{4'd1, 4'd1, 4'd2};
    bit seen;
    clear_codes();
    write_code(8'h00);
    cand_ready = 1'b0;
    start_scan(4'd2, 4'd1, 4'd1);
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (cand_valid === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_valid_timeout: cand_valid not seen within 50 cycles"); end
    n_checks++; if (cand_data !== 8'd1 || pass_count !== 9'd1) begin
      n_fail++; $display("FAIL bp_first: got data=%0d pass=%0d want data=1 pass=1", cand_data, pass_count);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (cand_valid !== 1'b1 || cand_data !== 8'd1 || cand_dist !== 4'd1 || pass_count !== 9'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid=%0b data=%0d dist=%0d pass=%0d want valid=1 data=1 dist=1 pass=1",
                 c, cand_valid, cand_data, cand_dist, pass_count);
      end
    end
    cand_ready = 1'b1;
    collect(100);
    n_checks++;
    if (cap_data.size() != 3) begin n_fail++; $display("FAIL bp_n_emit: got %0d want 3", cap_data.size()); end
    for (int i = 0; i < 3 && i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[i] !== exp_d[i] || cap_dist[i] !== exp_t[i] || cap_iso[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_emit[%0d]: got data=%0d dist=%0d iso=%0b want data=%0d dist=%0d iso=1",
                 i, cap_data[i], cap_dist[i], cap_iso[i], exp_d[i], exp_t[i]);
      end
    end
    n_checks++; if (pass_count !== 9'd3) begin n_fail++; $display("FAIL bp_pass: got %0d want 3", pass_count); end
  endtask

  task automatic test_capacity();
    clear_codes();
    for (int i = 0; i <= MAX_CODE; i++) begin
      write_code(WIDTH'(8'h10 + i));
      if (i == MAX_CODE - 2) begin
        n_checks++;
        if (code_count !== CW'(MAX_CODE - 1) || code_full !== 1'b0) begin
          n_fail++; $display("FAIL cap_almost: got count=%0d full=%0b want count=15 full=0", code_count, code_full);
        end
      end
    end
    n_checks++; if (code_count !== CW'(MAX_CODE)) begin n_fail++; $display("FAIL cap_count: got %0d want 16", code_count); end
    n_checks++; if (code_full !== 1'b1) begin n_fail++; $display("FAIL cap_full: got %0b want 1", code_full); end

    code_clear   = 1'b1;
    code_wr_en   = 1'b1;
    code_wr_data = 8'h33;
    tick();
    code_clear   = 1'b0;
    code_wr_en   = 1'b0;
    n_checks++; if (code_count !== '0 || code_full !== 1'b0) begin
      n_fail++; $display("FAIL cap_clear_prio: got count=%0d full=%0b want count=0 full=0", code_count, code_full);
    end

    write_code(8'h00);
    start_scan(4'd1, 4'd0, 4'd0);
    code_wr_en   = 1'b1;
    code_wr_data = 8'h55;
    tick();
    code_wr_en   = 1'b0;
    code_clear   = 1'b1;
    tick();
    code_clear   = 1'b0;
    collect(100);
    n_checks++; if (code_count !== CW'(1)) begin n_fail++; $display("FAIL cap_busy_write: got count=%0d want 1", code_count); end
    n_checks++; if (pass_count !== 9'd2) begin n_fail++; $display("FAIL cap_busy_pass: got %0d want 2", pass_count); end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    clear_codes();
    write_code(8'h00);
    cand_ready = 1'b0;
    start_scan(4'd4, 4'd3, 4'd4);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (cand_valid === 1'b1) begin seen = 1'b1; break; end
      tick();
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_valid_timeout: cand_valid not seen within 100 cycles"); end
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, cand_valid, cand_iso, code_full} !== 5'b0 || cand_data !== '0 || cand_dist !== '0 ||
        pass_count !== '0 || iso_count !== '0 || code_count !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_values: got busy=%0b done=%0b valid=%0b data=%0d iso=%0b dist=%0d pass=%0d isoc=%0d count=%0d full=%0b want all 0",
               busy, done, cand_valid, cand_data, cand_iso, cand_dist, pass_count, iso_count, code_count, code_full);
    end
    tick();
    reset_n    = 1'b1;
    cand_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done[%0d]: got %0b want 0", c, done); end
    end
    write_code(8'h00);
    start_scan(4'd4, 4'd3, 4'd4);
    collect(200);
    n_checks++;
    if (cap_data.size() != 5 || cap_data[0] !== 8'd7) begin
      n_fail++; $display("FAIL mid_restart_emit: got %0d emits want 5 starting at 7", cap_data.size());
    end
    n_checks++; if (pass_count !== 9'd5 || iso_count !== 9'd1) begin
      n_fail++; $display("FAIL mid_restart_counts: got pass=%0d isoc=%0d want pass=5 isoc=1", pass_count, iso_count);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    code_clear   = 1'b0;
    code_wr_en   = 1'b0;
    code_wr_data = '0;
    start        = 1'b0;
    n            = '0;
    min_hd       = '0;
    min_iso      = '0;
    cand_ready   = 1'b1;
    test_reset();
    test_single_word();
    test_two_word();
    test_empty_set();
    test_backpressure();
    test_capacity();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
